vector_buffer_fifo: RTL and testbench
=====================================

Name: vector_buffer_fifo

Overview:
- Parametrised successor to the 8-bit serial-to-parallel vector buffer.
- Assembles a serial bit stream into WIDTH-bit vectors and queues up to DEPTH completed vectors in an internal FIFO.
- Consumer pops vectors with a req/valid handshake.
- Sits between the serial bit source and the downstream vector consumer. Adds configurable bit order, queueing, fill level and overflow detection.

Parameters:
- WIDTH, 8, bits per assembled vector (>=2).
- DEPTH, 4, FIFO entries (power of two, >=2).
- MSB_FIRST, 1, 1: first received bit lands in vector[WIDTH-1]; 0: first bit lands in vector[0].

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- input_bit  input  1  serial data bit.
- bit_valid  input  1  input_bit sampled on a rising edge where high.
- req  input  1  consumer pop request; pop occurs on an edge where req && valid.
- overflow_clr  input  1  clears the sticky overflow flag.
- vector  output  WIDTH  head-of-FIFO vector; meaningful only while valid.
- valid  output  1  FIFO non-empty.
- level  output  $clog2(DEPTH+1)  number of queued vectors, 0..DEPTH.
- overflow  output  1  sticky; a completed vector was dropped.

Behaviour:
- Reset (rst_n low, asynchronous): vector=0, valid=0, level=0, overflow=0, bit counter=0, shift register=0, FIFO pointers=0. Bits and pops during reset are ignored.
- Assembler: bit counter 0..WIDTH-1 increments per sampled bit. Shift direction follows MSB_FIRST.
- Completion: when the WIDTH-th bit is sampled, the full vector (including that bit) is pushed on the same edge and the counter wraps to 0. Zero bubble: the next bit can be sampled the following cycle.
- Latency: last bit sampled at edge N on an empty FIFO -> valid=1 and vector correct after edge N.
- Pop: on an edge with req && valid, the head is removed; vector/valid/level reflect the new head after that edge. req with valid=0 is a no-op.
- Push and pop on the same edge: both happen; level unchanged. This holds when full (no overflow) and when level=1 (valid stays 1, vector shows the new entry).
- Full: push with level==DEPTH and no simultaneous pop -> new vector discarded, FIFO untouched, overflow<=1. The assembler still wraps and keeps accepting bits.
- overflow_clr: clears overflow on the next edge. If a drop occurs on the same edge, set wins (overflow stays 1).
- Pointers: wrap modulo DEPTH. level is a registered counter, never exceeds DEPTH, never underflows.
- bit_valid low: assembler holds its state indefinitely; a partial vector is retained.
- Reset mid-vector discards partial bits and all queued vectors.

Optional Feature:
- Macro: VECTOR_BUFFER_FLUSH_EN.
- Defined: extra input port `flush` (1 bit).
  - On an edge with flush=1 and bit counter>0, the partial vector is pushed zero-padded and the counter cleared. Padding sits in the positions not yet filled, per MSB_FIRST.
  - If bit_valid is high on the same edge, that bit is included first. If it completes the vector, exactly one push occurs.
  - flush with counter==0 and no bit is a no-op.
  - Full/overflow rules apply to flushed pushes.
- Undefined: no `flush` port; partial vectors complete only via bits.

Decomposition:
- Package vector_buffer_pkg: default WIDTH/DEPTH constants, a level-width helper function, and a bit-order enum or localparams (MSB_FIRST_ORDER, LSB_FIRST_ORDER).
- One sub-module, vector_fifo (DEPTH x WIDTH, push/pop/full/empty/level, simultaneous push+pop support).
- The top level holds the assembler, overflow and flush logic.

Test Plan:
- Reset value check (WIDTH=8, DEPTH=4): assert rst_n low mid-stream -> vector=0, valid=0, level=0, overflow=0 immediately, without waiting for a clock edge.
- Bit order: bits 1,0,1,1,0,0,1,0 with MSB_FIRST=1 -> vector=8'hB2, valid=1 after the 8th bit edge, level=1. Same bits with MSB_FIRST=0 -> vector=8'h4D.
- Fill and drain: push 4 vectors 8'h01..8'h04 with req=0 -> level=4. 5th vector 8'h05 -> dropped, overflow=1, level=4. Then req=1 for 4 cycles -> outputs 01,02,03,04, then valid=0.
- Simultaneous push/pop when full: level=4, complete a vector on the same edge as req=1 -> no overflow, level stays 4, new vector appears last in order.
- Gapped stream: bit_valid toggling every 3 cycles with alternating bits -> vector 8'hAA (MSB_FIRST=1, first bit 1). bit_valid=0 for 50 cycles mid-vector -> no spurious push.
- overflow_clr same edge as a drop -> overflow stays 1. With VECTOR_BUFFER_FLUSH_EN: 3 bits 1,1,1 then flush -> vector=8'hE0 (MSB_FIRST=1), counter cleared.

Source files
------------

// File: rtl/vector_buffer_pkg.sv
// Shared constants, bit-order encoding and sizing helper for the vector buffer FIFO.
package vector_buffer_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic {
        LSB_FIRST_ORDER = 1'b0,
        MSB_FIRST_ORDER = 1'b1
    } bit_order_e;

    // Bits needed to hold an occupancy count of 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vector_fifo.sv
// DEPTH x WIDTH circular FIFO with registered occupancy; push and pop may share an edge, even when full.
module vector_fifo
    import vector_buffer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_en;
    logic             pop_en;

    // A pop frees the head slot on the same edge, so a full FIFO can still accept.
    assign push_en = push && (!full || pop);
    assign pop_en  = pop && !empty;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/vector_buffer_fifo.sv
// Serial-to-parallel vector assembler feeding a vector FIFO, with sticky overflow.
// Define VECTOR_BUFFER_FLUSH_EN to add a `flush` input that pushes a zero-padded partial vector.
module vector_buffer_fifo
    import vector_buffer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       input_bit,
    input  logic                       bit_valid,
    input  logic                       req,
    input  logic                       overflow_clr,
`ifdef VECTOR_BUFFER_FLUSH_EN
    input  logic                       flush,
`endif
    output logic [WIDTH-1:0]           vector,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow
);

    localparam int         CW    = $clog2(WIDTH + 1);
    localparam bit_order_e ORDER = (MSB_FIRST != 0) ? MSB_FIRST_ORDER : LSB_FIRST_ORDER;

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] taken;
    logic [WIDTH-1:0] aligned;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    cnt_eff;
    logic [CW-1:0]    pad;
    logic             flush_req;
    logic             complete;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             drop;

`ifdef VECTOR_BUFFER_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // The incoming bit (if any) is folded in before deciding between completion and flush,
    // so a flush on the completing bit yields exactly one push.
    always_comb begin
        if (ORDER == MSB_FIRST_ORDER) begin
            shifted = {shift_reg[WIDTH-2:0], input_bit};
        end else begin
            shifted = {input_bit, shift_reg[WIDTH-1:1]};
        end
        taken    = bit_valid ? shifted : shift_reg;
        cnt_eff  = bit_cnt + CW'(bit_valid);
        pad      = CW'(WIDTH) - cnt_eff;
        aligned  = (ORDER == MSB_FIRST_ORDER) ? (taken << pad) : (taken >> pad);
        complete = (cnt_eff == CW'(WIDTH));
        push     = complete || (flush_req && (cnt_eff != '0));
    end

    assign pop   = req && !empty;
    assign drop  = push && full && !pop;
    assign valid = !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else if (bit_valid) begin
                bit_cnt   <= cnt_eff;
                shift_reg <= shifted;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    vector_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(aligned),
        .pop      (pop),
        .rd_data  (vector),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

endmodule

// File: tb/tb_vector_buffer_fifo.sv
// Scoreboard bench for vector_buffer_fifo (WIDTH=8, DEPTH=4) with an LSB-first companion instance.
module tb_vector_buffer_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       input_bit;
    logic       bit_valid;
    logic       req;
    logic       overflow_clr;
`ifdef VECTOR_BUFFER_FLUSH_EN
    logic       flush;
`endif
    logic [7:0] vector;
    logic       valid;
    logic [2:0] level;
    logic       overflow;
    logic [7:0] vector_l;
    logic       valid_l;
    logic [2:0] level_l;
    logic       overflow_l;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    always #5 clk = ~clk;

    vector_buffer_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .input_bit   (input_bit),
        .bit_valid   (bit_valid),
        .req         (req),
        .overflow_clr(overflow_clr),
`ifdef VECTOR_BUFFER_FLUSH_EN
        .flush       (flush),
`endif
        .vector      (vector),
        .valid       (valid),
        .level       (level),
        .overflow    (overflow)
    );

    vector_buffer_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(0)) dut_l (
        .clk         (clk),
        .rst_n       (rst_n),
        .input_bit   (input_bit),
        .bit_valid   (bit_valid),
        .req         (req),
        .overflow_clr(overflow_clr),
`ifdef VECTOR_BUFFER_FLUSH_EN
        .flush       (1'b0),
`endif
        .vector      (vector_l),
        .valid       (valid_l),
        .level       (level_l),
        .overflow    (overflow_l)
    );

    // Monitor: a pop happens on the coming rising edge, so the head shown now must match.
    always @(negedge clk) begin
        if (rst_n && req && valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got %02h, required no pop", vector);
            end else begin
                mon_exp = exp_q.pop_front();
                if (vector !== mon_exp) begin
                    n_fail++;
                    $display("FAIL pop_data: got %02h, required %02h", vector, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] v, input logic req_last, input logic clr_last);
        for (int i = 7; i >= 0; i--) begin
            input_bit = v[i];
            bit_valid = 1'b1;
            if (i == 0) begin
                req          = req_last;
                overflow_clr = clr_last;
            end
            tick();
        end
        bit_valid    = 1'b0;
        req          = 1'b0;
        overflow_clr = 1'b0;
    endtask

    task automatic drain(input int n);
        req = 1'b1;
        repeat (n) tick();
        req = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        input_bit    = 1'b0;
        bit_valid    = 1'b0;
        req          = 1'b0;
        overflow_clr = 1'b0;
`ifdef VECTOR_BUFFER_FLUSH_EN
        flush        = 1'b0;
`endif
        repeat (3) tick();
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_level", 32'(level), 32'd0);
        rst_n = 1'b1;
        tick();

        // Queue one vector plus a partial one, then reset asynchronously mid-cycle.
        send_bits(8'h3C, 1'b0, 1'b0);
        chk("pre_reset_valid", 32'(valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            input_bit = 1'b1;
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_vector", 32'(vector), 32'd0);
        chk("async_rst_valid", 32'(valid), 32'd0);
        chk("async_rst_level", 32'(level), 32'd0);
        chk("async_rst_overflow", 32'(overflow), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Bit order on both instances.
        send_bits(8'hB2, 1'b0, 1'b0);
        exp_q.push_back(8'hB2);
        chk("msb_valid", 32'(valid), 32'd1);
        chk("msb_level", 32'(level), 32'd1);
        chk("msb_vector", 32'(vector), 32'hB2);
        chk("lsb_vector", 32'(vector_l), 32'h4D);
        chk("lsb_level", 32'(level_l), 32'd1);
        drain(1);
        chk("pop_empty_valid", 32'(valid), 32'd0);
        chk("pop_empty_level", 32'(level), 32'd0);

        // Fill, overflow, drain.
        for (int v = 1; v <= 4; v++) begin
            send_bits(8'(v), 1'b0, 1'b0);
            exp_q.push_back(8'(v));
        end
        chk("fill_level", 32'(level), 32'd4);
        chk("fill_no_overflow", 32'(overflow), 32'd0);
        send_bits(8'h05, 1'b0, 1'b0);
        chk("drop_overflow", 32'(overflow), 32'd1);
        chk("drop_level", 32'(level), 32'd4);
        drain(4);
        chk("drained_valid", 32'(valid), 32'd0);
        chk("drained_level", 32'(level), 32'd0);
        chk("overflow_sticky", 32'(overflow), 32'd1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("overflow_cleared", 32'(overflow), 32'd0);

        // Push and pop on the same edge while full.
        for (int v = 8'h11; v <= 8'h14; v++) begin
            send_bits(8'(v), 1'b0, 1'b0);
            exp_q.push_back(8'(v));
        end
        send_bits(8'h15, 1'b1, 1'b0);
        exp_q.push_back(8'h15);
        chk("full_pushpop_level", 32'(level), 32'd4);
        chk("full_pushpop_overflow", 32'(overflow), 32'd0);
        drain(4);

        // Push and pop on the same edge at level 1.
        send_bits(8'h21, 1'b0, 1'b0);
        exp_q.push_back(8'h21);
        send_bits(8'h22, 1'b1, 1'b0);
        exp_q.push_back(8'h22);
        chk("l1_pushpop_level", 32'(level), 32'd1);
        chk("l1_pushpop_valid", 32'(valid), 32'd1);
        chk("l1_pushpop_vector", 32'(vector), 32'h22);
        drain(1);

        // Gapped stream with a long stall mid-vector.
        for (int i = 0; i < 8; i++) begin
            input_bit = (i % 2 == 0);
            bit_valid = 1'b1;
            tick();
            bit_valid = 1'b0;
            tick();
            tick();
            if (i == 3) begin
                repeat (50) tick();
                chk("stall_no_push_level", 32'(level), 32'd0);
                chk("stall_no_push_valid", 32'(valid), 32'd0);
            end
        end
        exp_q.push_back(8'hAA);
        chk("gapped_level", 32'(level), 32'd1);
        chk("gapped_vector", 32'(vector), 32'hAA);
        drain(1);

        // Clear on the same edge as a drop: set wins.
        for (int v = 8'h31; v <= 8'h34; v++) begin
            send_bits(8'(v), 1'b0, 1'b0);
            exp_q.push_back(8'(v));
        end
        send_bits(8'h35, 1'b0, 1'b0);
        chk("drop2_overflow", 32'(overflow), 32'd1);
        send_bits(8'h36, 1'b0, 1'b1);
        chk("clr_vs_drop_overflow", 32'(overflow), 32'd1);
        chk("clr_vs_drop_level", 32'(level), 32'd4);
        drain(4);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("overflow_cleared2", 32'(overflow), 32'd0);

`ifdef VECTOR_BUFFER_FLUSH_EN
        for (int i = 0; i < 3; i++) begin
            input_bit = 1'b1;
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.push_back(8'hE0);
        chk("flush_level", 32'(level), 32'd1);
        chk("flush_vector", 32'(vector), 32'hE0);
        send_bits(8'h5A, 1'b0, 1'b0);
        exp_q.push_back(8'h5A);
        chk("post_flush_level", 32'(level), 32'd2);
        drain(2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_empty_noop", 32'(level), 32'd0);
`endif

        tick();
        chk("all_expected_popped", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
